// File: rtl/neo_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : neo_stream_ctrl
// Description : Streaming Teager-Kaiser energy operator.
//               psi[n] = x[n-1]^2 - x[n]*x[n-2], with the sample history kept
//               in an external single-port-style ring memory (locations
//               1..M-1; location 0 is a scratch target for idle cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module neo_stream_ctrl #(
    parameter int N  = 16,
    parameter int M  = 32,
    localparam int AW = $clog2(M)
) (
    input  logic                  Clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [N-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [2*N:0]   out_data,
    output logic [AW-1:0]         mem_waddr,
    output logic signed [N-1:0]   mem_wdata,
    output logic [AW-1:0]         mem_raddr,
    input  logic signed [N-1:0]   mem_rdata
);

    localparam logic [AW-1:0] c_RING_FIRST  = AW'(1);
    localparam logic [AW-1:0] c_RING_SECOND = AW'(2);
    localparam logic [AW-1:0] c_RING_LAST   = AW'(M - 1);
    localparam logic [AW-1:0] c_RING_PENULT = AW'(M - 2);
    localparam logic [AW-1:0] c_ADDR_ZERO   = '0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD1  = 3'd1,
        S_RD2  = 3'd2,
        S_RD3  = 3'd3,
        S_CALC = 3'd4,
        S_OUT  = 3'd5
    } state_t;

    state_t                 r_state;
    logic [AW-1:0]          r_wptr;
    logic [1:0]             r_warm_cnt;
    logic signed [N-1:0]    r_x_cur;
    logic signed [N-1:0]    r_x_p1;
    logic signed [N-1:0]    r_x_p2;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic signed [2*N:0]    r_out_data;
    logic [AW-1:0]          r_mem_waddr;
    logic signed [N-1:0]    r_mem_wdata;
    logic [AW-1:0]          r_mem_raddr;

    logic [AW-1:0]          w_wptr_m1;
    logic [AW-1:0]          w_wptr_m2;
    logic [AW-1:0]          w_wptr_p1;
    logic signed [2*N-1:0]  w_sq;
    logic signed [2*N-1:0]  w_cross;
    logic signed [2*N:0]    w_psi;
    logic                   w_warm;

    // Ring neighbours: the ring skips location 0, so wrap lands on M-1 / 1.
    assign w_wptr_m1 = (r_wptr == c_RING_FIRST)  ? c_RING_LAST   : r_wptr - AW'(1);
    assign w_wptr_m2 = (r_wptr == c_RING_FIRST)  ? c_RING_PENULT :
                       (r_wptr == c_RING_SECOND) ? c_RING_LAST   : r_wptr - AW'(2);
    assign w_wptr_p1 = (r_wptr == c_RING_LAST)   ? c_RING_FIRST  : r_wptr + AW'(1);

    // Full-precision products, one extra bit for the difference.
    assign w_sq    = r_x_p1 * r_x_p1;
    assign w_cross = r_x_cur * r_x_p2;
    assign w_psi   = {w_sq[2*N-1], w_sq} - {w_cross[2*N-1], w_cross};

    // Two completed samples are needed before a third has both neighbours.
    assign w_warm  = (r_warm_cnt == 2'd2);

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign mem_waddr = r_mem_waddr;
    assign mem_wdata = r_mem_wdata;
    assign mem_raddr = r_mem_raddr;

    // Sample sequencer: fetch two neighbours, write current sample, compute, hand off.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_wptr      <= c_RING_FIRST;
            r_warm_cnt  <= 2'd0;
            r_x_cur     <= '0;
            r_x_p1      <= '0;
            r_x_p2      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_mem_waddr <= c_ADDR_ZERO;
            r_mem_wdata <= '0;
            r_mem_raddr <= c_ADDR_ZERO;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x_cur     <= in_data;
                        r_mem_raddr <= w_wptr_m1;
                        r_in_ready  <= 1'b0;
                        r_state     <= S_RD1;
                    end
                end
                S_RD1: begin
                    r_mem_raddr <= w_wptr_m2;
                    r_state     <= S_RD2;
                end
                S_RD2: begin
                    r_x_p1  <= mem_rdata;
                    r_state <= S_RD3;
                end
                S_RD3: begin
                    // Read address stays at wptr-2, never equal to the write address.
                    r_x_p2      <= mem_rdata;
                    r_mem_waddr <= r_wptr;
                    r_mem_wdata <= r_x_cur;
                    r_state     <= S_CALC;
                end
                S_CALC: begin
                    r_mem_waddr <= c_ADDR_ZERO;
                    r_mem_wdata <= '0;
                    r_mem_raddr <= c_ADDR_ZERO;
                    r_wptr      <= w_wptr_p1;
                    if (!w_warm) begin
                        r_warm_cnt <= r_warm_cnt + 2'd1;
                    end
                    if (w_warm) begin
                        r_out_data  <= w_psi;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end else begin
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_mem_waddr <= c_ADDR_ZERO;
                    r_mem_wdata <= '0;
                    r_mem_raddr <= c_ADDR_ZERO;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
